noc_system: RTL and testbench

NOC_SYSTEM -- requirements
Module: noc_system

---
 rtl/noc_system.sv | 165 ++++++++++++++++
 tb/tb_noc_system.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_system.sv
// Single-input, two-output wormhole NoC node: input FIFO, one-flit routing stage,
// and two output FIFOs with atomic multicast into both outputs.
module noc_system #(
  parameter int DW        = 32,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] data_i_stab,
  input  logic          valid_i_stab,
  output logic          ready_o_stab,
  output logic [DW-1:0] data_o_flee0,
  output logic          valid_o_flee0,
  input  logic          ready_i_flee0,
  output logic [DW-1:0] data_o_flee1,
  output logic          valid_o_flee1,
  input  logic          ready_i_flee1
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b01;

  function automatic logic [1:0] flit_type(input logic [DW-1:0] f);
    return f[DW-1:DW-2];
  endfunction

  function automatic logic [1:0] flit_mask(input logic [DW-1:0] f);
    return f[DW-3:DW-4];
  endfunction

  logic                rdy_r;
  logic [DW-1:0]       in_mem_r [IN_DEPTH];
  logic [IAW:0]        in_wr_r;
  logic [IAW:0]        in_rd_r;
  logic                in_full_s;
  logic                in_empty_s;
  logic                in_push_s;
  logic                in_pop_s;
  logic [DW-1:0]       in_head_s;
  logic [1:0]          head_type_s;
  logic [1:0]          head_mask_s;
  logic [1:0]          route_r;

  logic                stg_valid_r;
  logic [DW-1:0]       stg_data_r;
  logic [1:0]          stg_mask_r;
  logic                stg_adv_s;

  logic [DW-1:0]       out_mem_r [2][OUT_DEPTH];
  logic [OAW:0]        out_wr_r [2];
  logic [OAW:0]        out_rd_r [2];
  logic [1:0]          out_full_s;
  logic [1:0]          out_empty_s;
  logic [1:0]          out_pop_s;
  logic [1:0]          out_push_s;
  logic [1:0]          out_space_s;
  logic [1:0]          snk_rdy_s;

  assign snk_rdy_s    = {ready_i_flee1, ready_i_flee0};
  // rdy_r holds ready low until the first edge after reset release
  assign ready_o_stab = rdy_r && !in_full_s;
  assign in_push_s    = valid_i_stab && ready_o_stab;
  assign in_head_s    = in_mem_r[in_rd_r[IAW-1:0]];
  assign head_type_s  = flit_type(in_head_s);

  assign valid_o_flee0 = !out_empty_s[0];
  assign valid_o_flee1 = !out_empty_s[1];
  assign data_o_flee0  = out_mem_r[0][out_rd_r[0][OAW-1:0]];
  assign data_o_flee1  = out_mem_r[1][out_rd_r[1][OAW-1:0]];

  // Input FIFO status and route resolution for the flit at its head
  always_comb begin
    in_empty_s  = (in_wr_r == in_rd_r);
    in_full_s   = (in_wr_r[IAW] != in_rd_r[IAW]) &&
                  (in_wr_r[IAW-1:0] == in_rd_r[IAW-1:0]);
    head_mask_s = route_r;
    if (head_type_s[1]) begin
      head_mask_s = flit_mask(in_head_s);
    end else begin
      head_mask_s = route_r;
    end
    in_pop_s = !in_empty_s && (!stg_valid_r || stg_adv_s);
  end

  // Output FIFO status; a pop frees a full FIFO for a same-cycle push
  always_comb begin
    out_empty_s = 2'b00;
    out_full_s  = 2'b00;
    out_pop_s   = 2'b00;
    out_space_s = 2'b00;
    for (int p = 0; p < 2; p++) begin
      out_empty_s[p] = (out_wr_r[p] == out_rd_r[p]);
      out_full_s[p]  = (out_wr_r[p][OAW] != out_rd_r[p][OAW]) &&
                       (out_wr_r[p][OAW-1:0] == out_rd_r[p][OAW-1:0]);
      out_pop_s[p]   = !out_empty_s[p] && snk_rdy_s[p];
      out_space_s[p] = !out_full_s[p] || out_pop_s[p];
    end
    stg_adv_s  = stg_valid_r &&
                 (!stg_mask_r[0] || out_space_s[0]) &&
                 (!stg_mask_r[1] || out_space_s[1]);
    out_push_s = stg_adv_s ? stg_mask_r : 2'b00;
  end

  // FIFO storage writes (contents need no reset, pointers gate visibility)
  always_ff @(posedge clk) begin
    if (in_push_s) begin
      in_mem_r[in_wr_r[IAW-1:0]] <= data_i_stab;
    end
    for (int p = 0; p < 2; p++) begin
      if (out_push_s[p]) begin
        out_mem_r[p][out_wr_r[p][OAW-1:0]] <= stg_data_r;
      end
    end
  end

  // Pointers, wormhole route latch and routing stage register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_r       <= 1'b0;
      in_wr_r     <= '0;
      in_rd_r     <= '0;
      route_r     <= 2'b00;
      stg_valid_r <= 1'b0;
      stg_data_r  <= '0;
      stg_mask_r  <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        out_wr_r[p] <= '0;
        out_rd_r[p] <= '0;
      end
    end else begin
      rdy_r <= 1'b1;
      if (in_push_s) begin
        in_wr_r <= in_wr_r + 1'b1;
      end
      if (in_pop_s) begin
        in_rd_r <= in_rd_r + 1'b1;
        case (head_type_s)
          T_HEAD:  route_r <= flit_mask(in_head_s);
          T_TAIL:  route_r <= 2'b00;
          default: route_r <= route_r;
        endcase
      end
      // Unrouted flits are consumed here without ever entering the stage
      if (in_pop_s && (head_mask_s != 2'b00)) begin
        stg_valid_r <= 1'b1;
        stg_data_r  <= in_head_s;
        stg_mask_r  <= head_mask_s;
      end else if (stg_adv_s) begin
        stg_valid_r <= 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (out_push_s[p]) begin
          out_wr_r[p] <= out_wr_r[p] + 1'b1;
        end
        if (out_pop_s[p]) begin
          out_rd_r[p] <= out_rd_r[p] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_system.sv
// Directed and randomised checks for noc_system: latency, wormhole routing,
// multicast atomicity, backpressure depth and reset recovery.
module tb_noc_system;

  localparam int NPKT = 10000;

  logic        clk;
  logic        rstn;
  logic [31:0] data_i_stab;
  logic        valid_i_stab;
  logic        ready_o_stab;
  logic [31:0] data_o_flee0;
  logic        valid_o_flee0;
  logic        ready_i_flee0;
  logic [31:0] data_o_flee1;
  logic        valid_o_flee1;
  logic        ready_i_flee1;

  int vec_cnt;
  int miss_cnt;

  noc_system #(.DW(32), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .data_i_stab   (data_i_stab),
    .valid_i_stab  (valid_i_stab),
    .ready_o_stab  (ready_o_stab),
    .data_o_flee0  (data_o_flee0),
    .valid_o_flee0 (valid_o_flee0),
    .ready_i_flee0 (ready_i_flee0),
    .data_o_flee1  (data_o_flee1),
    .valid_o_flee1 (valid_o_flee1),
    .ready_i_flee1 (ready_i_flee1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] d);
    data_i_stab  = d;
    valid_i_stab = 1'b1;
    tick();
    valid_i_stab = 1'b0;
  endtask

  logic [31:0] pk [3];
  logic [31:0] mc_exp [4];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] cur;
  logic [1:0]  pmask;
  logic [1:0]  cur_m;
  int          acc;
  int          got;
  int          pkts;
  int          pleft;
  int          len;
  bit          pend;
  bit          was;
  bit          seen;
  bit          rst_done;
  bit          done;

  initial begin
    vec_cnt = 0; miss_cnt = 0;
    rstn = 1'b0; valid_i_stab = 1'b0; data_i_stab = 32'd0;
    ready_i_flee0 = 1'b1; ready_i_flee1 = 1'b1;

    // Reset state and ready rising on the first edge after release
    repeat (3) tick();
    chk_eq("rst_ready", {31'd0, ready_o_stab}, 32'd0);
    chk_eq("rst_v0", {31'd0, valid_o_flee0}, 32'd0);
    chk_eq("rst_v1", {31'd0, valid_o_flee1}, 32'd0);
    rstn = 1'b1;
    #1;
    chk_eq("ready_pre_edge", {31'd0, ready_o_stab}, 32'd0);
    tick();
    chk_eq("ready_post_edge", {31'd0, ready_o_stab}, 32'd1);

    // 0xC5A5A5A5 decodes to SINGLE with mask 00, so it is dropped
    push_one(32'hC5A5A5A5);
    repeat (3) tick();
    chk_eq("mask00_drop", {30'd0, valid_o_flee1, valid_o_flee0}, 32'd0);

    // SINGLE mask 01: visible on flee0 exactly two edges after acceptance
    push_one(32'hD5A5A5A5);
    chk_eq("lat_n0", {31'd0, valid_o_flee0}, 32'd0);
    tick();
    chk_eq("lat_n1", {31'd0, valid_o_flee0}, 32'd0);
    tick();
    chk_eq("lat_n2_v0", {31'd0, valid_o_flee0}, 32'd1);
    chk_eq("lat_n2_d0", data_o_flee0, 32'hD5A5A5A5);
    chk_eq("lat_n2_v1", {31'd0, valid_o_flee1}, 32'd0);
    tick();
    chk_eq("lat_popped", {31'd0, valid_o_flee0}, 32'd0);

    // HEAD/BODY/TAIL to flee1, back to back in and out
    pk[0] = 32'hA0000001; pk[1] = 32'h00000002; pk[2] = 32'h40000003;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        data_i_stab = pk[c]; valid_i_stab = 1'b1;
      end else begin
        valid_i_stab = 1'b0;
      end
      tick();
      if (c >= 2 && c <= 4) begin
        chk_eq("worm_v1", {31'd0, valid_o_flee1}, 32'd1);
        chk_eq("worm_d1", data_o_flee1, pk[c-2]);
        chk_eq("worm_v0", {31'd0, valid_o_flee0}, 32'd0);
      end
    end

    // Multicast SINGLE reaches both ports in the same cycle
    push_one(32'hF0000007);
    tick();
    tick();
    chk_eq("mc_v0", {31'd0, valid_o_flee0}, 32'd1);
    chk_eq("mc_v1", {31'd0, valid_o_flee1}, 32'd1);
    chk_eq("mc_d0", data_o_flee0, 32'hF0000007);
    chk_eq("mc_d1", data_o_flee1, 32'hF0000007);
    repeat (2) tick();

    // Backpressure: 4 input + 1 stage + 4 output = 9 flits, then drain in order
    ready_i_flee0 = 1'b0;
    acc = 0;
    for (int c = 0; c < 16; c++) begin
      data_i_stab = 32'hD0000100 + acc; valid_i_stab = 1'b1;
      was = ready_o_stab;
      tick();
      if (was) acc++;
    end
    valid_i_stab = 1'b0;
    chk_eq("fill_cnt", acc, 32'd9);
    chk_eq("fill_ready", {31'd0, ready_o_stab}, 32'd0);
    ready_i_flee0 = 1'b1;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (valid_o_flee0) begin
        chk_eq("drain_d0", data_o_flee0, 32'hD0000100 + got);
        got++;
      end
      tick();
    end
    chk_eq("drain_cnt", got, 32'd9);

    // Multicast held while flee1 is full, even though flee0 is ready
    ready_i_flee1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_i_stab = 32'hE0000010 + i; valid_i_stab = 1'b1;
      tick();
    end
    push_one(32'hF00000AA);
    repeat (8) tick();
    chk_eq("mc_hold_v0", {31'd0, valid_o_flee0}, 32'd0);
    chk_eq("mc_hold_d1", data_o_flee1, 32'hE0000010);
    ready_i_flee1 = 1'b1;
    tick();
    chk_eq("mc_rel_v0", {31'd0, valid_o_flee0}, 32'd1);
    chk_eq("mc_rel_d0", data_o_flee0, 32'hF00000AA);
    mc_exp[0] = 32'hE0000011; mc_exp[1] = 32'hE0000012;
    mc_exp[2] = 32'hE0000013; mc_exp[3] = 32'hF00000AA;
    for (int k = 0; k < 4; k++) begin
      chk_eq("mc_rel_d1", data_o_flee1, mc_exp[k]);
      tick();
    end
    repeat (4) tick();

    // Reset mid-packet clears the route: a following BODY goes nowhere
    push_one(32'h90000001);
    repeat (4) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    push_one(32'h00000055);
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen |= valid_o_flee0 | valid_o_flee1;
    end
    chk_eq("rst_route_clr", {31'd0, seen}, 32'd0);
    push_one(32'hD0000066);
    tick();
    tick();
    chk_eq("post_rst_d0", data_o_flee0, 32'hD0000066);
    tick();

    // Random packets with a reference model and one mid-packet reset
    pkts = 0; pleft = 0; pend = 1'b0; rst_done = 1'b0; done = 1'b0;
    pmask = 2'b00; cur_m = 2'b00; cur = 32'd0;
    for (int cyc = 0; cyc < 90000; cyc++) begin
      if (valid_o_flee0) begin
        if (q0.size() == 0) chk_eq("p0_extra", {31'd0, valid_o_flee0}, 32'd0);
        else chk_eq("p0_data", data_o_flee0, q0.pop_front());
      end
      if (valid_o_flee1) begin
        if (q1.size() == 0) chk_eq("p1_extra", {31'd0, valid_o_flee1}, 32'd0);
        else chk_eq("p1_data", data_o_flee1, q1.pop_front());
      end
      if (!rst_done && pkts >= NPKT / 2 && pleft > 0) begin
        rstn = 1'b0; valid_i_stab = 1'b0;
        pend = 1'b0; pleft = 0;
        q0.delete(); q1.delete();
        #1;
        chk_eq("rnd_rst_v", {30'd0, valid_o_flee1, valid_o_flee0}, 32'd0);
        tick();
        tick();
        rstn = 1'b1; rst_done = 1'b1;
        tick();
        continue;
      end
      if (pkts >= NPKT && pleft == 0 && !pend && q0.size() == 0 && q1.size() == 0) begin
        done = 1'b1;
        break;
      end
      if (!pend && (pkts < NPKT || pleft > 0) && $urandom_range(9, 0) != 0) begin
        if (pleft == 0) begin
          len = $urandom_range(3, 1);
          pmask = 2'($urandom_range(3, 0));
          pkts++;
          pleft = len;
          cur = {((len == 1) ? 2'b11 : 2'b10), pmask, 28'($urandom)};
        end else begin
          cur = {((pleft == 1) ? 2'b01 : 2'b00), 30'($urandom)};
        end
        cur_m = pmask;
        pleft--;
        pend = 1'b1;
      end
      valid_i_stab = pend;
      data_i_stab  = cur;
      was = pend && ready_o_stab;
      tick();
      if (was) begin
        if (cur_m[0]) q0.push_back(cur);
        if (cur_m[1]) q1.push_back(cur);
        pend = 1'b0;
      end
    end
    valid_i_stab = 1'b0;
    chk_eq("rand_done", {31'd0, done}, 32'd1);
    chk_eq("rand_rst_hit", {31'd0, rst_done}, 32'd1);
    repeat (5) tick();
    chk_eq("rand_idle", {30'd0, valid_o_flee1, valid_o_flee0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
